seq_subtractor_8: RTL and testbench
===================================

SEQ_SUBTRACTOR_8 -- requirements
Module: seq_subtractor_8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, the request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits, the minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits, the subtrahend.
REQ-007 The block SHALL have port bin, input, 1 bit, the borrow-in.
REQ-008 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port diff, output, WIDTH bits, the result a - b - bin modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit, the borrow-out; it is 1 when a < b + bin, unsigned.
REQ-012 The block SHALL have port ovf, output, 1 bit, the signed overflow flag; this port is present only under SEQ_SUB_OVF_EN.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 SHALL capture a, b and bin into internal shift registers, clear the bit counter and move the FSM to RUN.
REQ-015 In RUN, one bit per cycle SHALL be processed, LSB first, through a 1-bit full subtractor with a registered borrow.
REQ-016 After WIDTH RUN cycles the FSM SHALL go to DONE.
REQ-017 Latency: start sampled at edge N SHALL produce RUN in cycles N+1..N+WIDTH and done=1 in cycle N+WIDTH+1.
REQ-018 diff and bout SHALL update only on the RUN-to-DONE transition and SHALL hold until the next result; no partial value SHALL ever appear on diff.
REQ-019 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-021 start=1 during DONE SHALL be accepted, with the same effect as in IDLE (back-to-back operation, DONE to RUN).
REQ-022 start SHALL be ignored during RUN, and the operands already captured SHALL be unaffected.
REQ-023 Input changes on a, b and bin outside the capture edge SHALL have no effect.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.

Reset
REQ-025 rst=1 SHALL force IDLE and set busy=0, done=0, diff=0, bout=0 and ovf=0 on the next edge, in any state, including mid-RUN; the partial operation is discarded.
REQ-026 rst SHALL take priority over start on the same edge.
REQ-027 Only the reset values SHALL be relied upon; no initial blocks SHALL be used for state.

Configuration
REQ-028 With macro SEQ_SUB_OVF_EN defined, port ovf SHALL exist and SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the captured operands and the final result, registered with diff.
REQ-029 With SEQ_SUB_OVF_EN undefined, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package seq_sub_pkg SHALL hold the default WIDTH constant and the state enum typedef (IDLE, RUN, DONE).
REQ-031 Sub-module full_subtractor SHALL be purely combinational: inputs x, y and bi; outputs d = x^y^bi and bo = (~x&y) | (~(x^y)&bi).
REQ-032 seq_subtractor_8 SHALL instantiate full_subtractor exactly once.

Verification
REQ-033 Reset, then a=5, b=2, bin=0, start pulse -> done=1 nine cycles later, diff=3, bout=0, ovf=0.
REQ-034 a=20, b=20, bin=1 -> diff=0xFF, bout=1; a=1, b=1, bin=0 -> diff=0, bout=0.
REQ-035 a=128, b=1, bin=0 with SEQ_SUB_OVF_EN -> diff=127, bout=0, ovf=1; a=200, b=20 -> diff=180, ovf=0.
REQ-036 start held high during RUN with changing a and b -> original result only, busy high 8 cycles, single done pulse; start in the DONE cycle -> second result exactly 9 cycles later.
REQ-037 rst asserted in RUN cycle 4 -> next cycle busy=0, done=0, diff=0; a fresh start then completes correctly.
REQ-038 Self-check for a 256-pair random sweep -> diff == (a - b - bin) mod 256 and bout == (a < b + bin) for every pair.

Source files
------------

// File: rtl/seq_sub_pkg.sv
// Shared constants and types for the bit-serial subtractor.
// The signed-overflow output is built only when SEQ_SUB_OVF_EN is defined.
package seq_sub_pkg;

  // Operand width used when the top is instantiated without overrides
  localparam int SEQ_SUB_WIDTH = 8;

  // Control states: wait for start, shift one bit per cycle, present result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself so it never wraps mid-operation
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_subtractor_8_fs.sv
// One-bit full subtractor: d = x - y - bi, bo = borrow out.
// Purely combinational; the serial datapath registers the borrow around it.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/seq_subtractor_8.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A start in IDLE or DONE captures the operands; WIDTH RUN cycles later the
// result lands on diff/bout in one step and done pulses for one cycle.
// Define SEQ_SUB_OVF_EN to add the registered signed-overflow output ovf.
// WIDTH must be at least 2.
module seq_subtractor_8
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = SEQ_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SEQ_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int CW = cnt_bits(WIDTH);
  // Accumulator keeps the WIDTH-1 low result bits; the MSB comes straight
  // from the subtractor on the final cycle.
  localparam int AW = WIDTH - 1;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [AW-1:0]   acc_sr;
  logic [CW-1:0]   cnt;
  logic            brw;
  logic            fs_d, fs_bo;
  logic            cap;
  logic            last;

  // Operands are accepted whenever the engine is not mid-operation
  assign cap  = start && ((state == IDLE) || (state == DONE));
  assign last = (cnt == CW'(WIDTH - 1));

  full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (brw),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // State register; reset wins over any start on the same edge
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: DONE lasts one cycle, and a start there chains straight to RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are pure decodes of the state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Serial datapath: capture on start, then shift one bit per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
    end else if (cap) begin
      a_sr   <= a;
      b_sr   <= b;
      acc_sr <= '0;
      brw    <= bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      acc_sr <= (acc_sr >> 1) | (AW'(fs_d) << (AW - 1));
      brw    <= fs_bo;
      cnt    <= cnt + CW'(1);
    end
  end

  // Result registers load once, on the RUN-to-DONE edge, so diff never
  // shows a partially shifted value
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
    end else if ((state == RUN) && last) begin
      diff <= {fs_d, acc_sr};
      bout <= fs_bo;
    end
  end

`ifdef SEQ_SUB_OVF_EN
  logic a_msb, b_msb;

  // Operand sign bits are shifted out of a_sr/b_sr, so keep copies
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (cap) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end
  end

  // Overflow: operands of opposite sign and the result sign differs from a
  always_ff @(posedge clk) begin
    if (rst)                          ovf <= 1'b0;
    else if ((state == RUN) && last)  ovf <= (a_msb != b_msb) && (fs_d != a_msb);
  end
`endif

endmodule

// File: tb/tb_seq_subtractor_8.sv
// Scoreboard bench for seq_subtractor_8: the driver pushes the expected
// result and completion cycle for every accepted start; the monitor checks
// busy/done timing, results and result hold every cycle.
module tb_seq_subtractor_8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SEQ_SUB_OVF_EN
  logic         ovf;
`endif

  seq_subtractor_8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SEQ_SUB_OVF_EN
    .bout  (bout),
    .ovf   (ovf)
`else
    .bout  (bout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic bi, input int c);
    exp_t e;
    int   r, s;
    r = int'(av) - int'(bv) - int'(bi);
    s = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    e.diff = W'(r);
    e.bout = (r < 0);
    e.ovf  = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
    e.cyc  = c;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  exp_t         e;
  logic         exp_done, exp_busy;
  logic [W-1:0] hold_diff;
  logic         hold_bout, hold_ovf;

  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (rst) begin
      q.delete();
      hold_diff = '0;
      hold_bout = 1'b0;
      hold_ovf  = 1'b0;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_diff", 32'(diff), 32'(0));
      chk("rst_bout", 32'(bout), 32'(0));
`ifdef SEQ_SUB_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'(0));
`endif
    end else begin
      exp_done = (q.size() > 0) && (cyc == q[0].cyc);
      exp_busy = (q.size() > 0) && (cyc >= q[0].cyc - W) && (cyc < q[0].cyc);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        e = q.pop_front();
        chk("diff", 32'(diff), 32'(e.diff));
        chk("bout", 32'(bout), 32'(e.bout));
`ifdef SEQ_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
        hold_diff = e.diff;
        hold_bout = e.bout;
        hold_ovf  = e.ovf;
      end else begin
        chk("hold_diff", 32'(diff), 32'(hold_diff));
        chk("hold_bout", 32'(bout), 32'(hold_bout));
`ifdef SEQ_SUB_OVF_EN
        chk("hold_ovf", 32'(ovf), 32'(hold_ovf));
`endif
      end
    end
  end

  // Issue one start at the current falling edge; optionally keep start high
  // (with junk operands) for 'hold' more cycles while the DUT is running.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                    input logic bi, input int hold);
    a = av; b = bv; bin = bi; start = 1'b1;
    q.push_back(model(av, bv, bi, cyc + W + 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  // Park on the falling edge where done is visible (bounded)
  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed values, mostly back-to-back from the DONE cycle
    op(8'd5, 8'd2, 1'b0, 0);     wait_done(); @(negedge clk);
    op(8'd20, 8'd20, 1'b1, 0);   wait_done();
    op(8'd1, 8'd1, 1'b0, 0);     wait_done();
    op(8'd128, 8'd1, 1'b0, 0);   wait_done();
    op(8'd200, 8'd20, 1'b0, 0);  wait_done();
    @(negedge clk);

    // start held through RUN with changing operands, then chained start
    op(8'h3c, 8'h5a, 1'b1, 7);   wait_done();
    op(8'h0f, 8'hf0, 1'b0, 0);   wait_done();
    @(negedge clk);

    // Reset in the middle of RUN discards the operation
    op(8'h77, 8'h11, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op(8'h99, 8'h33, 1'b1, 0);   wait_done();
    @(negedge clk);

    // Reset and start together: reset wins, no operation starts
    rst = 1'b1; start = 1'b1; a = 8'h42; b = 8'h24;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    // Random sweep with random gaps and random start-hold lengths
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
